// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_pkg
//  Purpose  : Shared encodings for the irrigation sequencer and the timer's
//             preset encoder (state codes and irrigation type codes).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PURGE    = 2'b01,
        ST_IRRIGATE = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    localparam logic [1:0] TY_NONE      = 2'b00;
    localparam logic [1:0] TY_DRIP      = 2'b01;
    localparam logic [1:0] TY_SPRINKLER = 2'b10;

    // Only drip and sprinkler are real irrigation types; 00 and 11 are rejected.
    function automatic logic type_is_valid(input logic [1:0] t);
        return (t == TY_DRIP) || (t == TY_SPRINKLER);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_sequencer_transition_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : transition_watchdog
//  Purpose  : Arm handshake and watchdog for one timer run. A load strobe
//             clears the armed flag; the first cycle with timer_done=0 arms
//             it, so a stale timer_done=1 from the previous run is ignored.
//             Flags a timeout if arming takes too long or if the armed timer
//             never finishes.
//  Ports    : clk, rst_n          clock, async active-low reset
//             i_load             preset-load strobe (state-change pulse)
//             i_timer_done       timer at zero
//             o_expired          armed timer has reached zero
//             o_timeout          arm or run watchdog exceeded
//  Revision : 1.0  initial release
// ============================================================================
module transition_watchdog #(
    parameter int ARM_MAX     = 4,
    parameter int WDOG_CYCLES = 63,
    parameter int WDOG_W      = 6     // 2**WDOG_W must exceed WDOG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_timer_done,
    output logic o_expired,
    output logic o_timeout
);

    // The counter holds (cycles spent in the current phase - 1), so the
    // comparisons fire in the ARM_MAX-th unarmed cycle after the load and in
    // the WDOG_CYCLES-th cycle after the arming cycle.
    localparam logic [WDOG_W-1:0] c_ARM_LAST  = WDOG_W'(ARM_MAX - 1);
    localparam logic [WDOG_W-1:0] c_WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WDOG_W-1:0] c_CNT_MAX   = '1;

    logic              r_armed;
    logic [WDOG_W-1:0] r_cnt;
    logic              w_arm_to;
    logic              w_run_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (!r_armed && !i_timer_done) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_arm_to = !r_armed && i_timer_done  && (r_cnt >= c_ARM_LAST);
    assign w_run_to =  r_armed && !i_timer_done && (r_cnt >= c_WDOG_LAST);

    // During the load cycle the flag still belongs to the previous run.
    assign o_expired = !i_load && r_armed && i_timer_done;
    assign o_timeout = !i_load && (w_arm_to || w_run_to);

endmodule
`default_nettype wire

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_sequencer
//  Purpose  : Control FSM upstream of the irrigation timer.
//             IDLE -> PURGE -> IRRIGATE -> IDLE, FAULT on water loss or
//             watchdog. Every state change emits a one-cycle load strobe.
//  Ports    : clk, rst_n              clock, async active-low reset
//             i_start                 level request to irrigate
//             i_humidity_low          soil is dry
//             i_water_low             reservoir below minimum
//             i_type_sel[1:0]         01 drip, 10 sprinkler
//             i_fault_clr             operator acknowledge
//             i_timer_done            timer clk_off
//             o_state[1:0]            00 IDLE 01 PURGE 10 IRRIGATE 11 FAULT
//             o_irrigation_type[1:0]  latched type, 00 in IDLE/FAULT
//             o_pulse_transiction     preset-load strobe
//             o_purge_on, o_valve_on, o_alarm   actuators
//  Revision : 1.0  initial release
// ============================================================================
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int ARM_MAX     = 4,
    parameter int WDOG_CYCLES = 63,
    parameter int WDOG_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_humidity_low,
    input  logic       i_water_low,
    input  logic [1:0] i_type_sel,
    input  logic       i_fault_clr,
    input  logic       i_timer_done,
    output logic [1:0] o_state,
    output logic [1:0] o_irrigation_type,
    output logic       o_pulse_transiction,
    output logic       o_purge_on,
    output logic       o_valve_on,
    output logic       o_alarm
);

    state_e     r_state;
    logic [1:0] r_type;
    logic       r_pulse;
    logic       r_purge;
    logic       r_valve;
    logic       r_alarm;

    state_e     w_next;
    logic [1:0] w_next_type;
    logic       w_expired;
    logic       w_timeout;

    transition_watchdog #(
        .ARM_MAX     (ARM_MAX),
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) u_wdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (r_pulse),
        .i_timer_done (i_timer_done),
        .o_expired    (w_expired),
        .o_timeout    (w_timeout)
    );

    // State and all outputs are registered together so every output
    // changes on the same edge as the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_type  <= TY_NONE;
            r_pulse <= 1'b0;
            r_purge <= 1'b0;
            r_valve <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_next;
            r_type  <= w_next_type;
            r_pulse <= (w_next != r_state);
            r_purge <= (w_next == ST_PURGE);
            r_valve <= (w_next == ST_IRRIGATE);
            r_alarm <= (w_next == ST_FAULT);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_next_type = TY_NONE;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start && i_humidity_low && !i_water_low &&
                    type_is_valid(i_type_sel))
                    w_next = ST_PURGE;
            end
            ST_PURGE: begin
                // Water loss and watchdog outrank a coincident expiry.
                if (i_water_low || w_timeout)
                    w_next = ST_FAULT;
                else if (w_expired)
                    w_next = ST_IRRIGATE;
            end
            ST_IRRIGATE: begin
                if (i_water_low || w_timeout)
                    w_next = ST_FAULT;
                else if (w_expired || !i_humidity_low)
                    w_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (i_fault_clr && !i_water_low)
                    w_next = ST_IDLE;
            end
        endcase

        // Type is captured on the IDLE->PURGE edge and held through IRRIGATE.
        if (r_state == ST_IDLE && w_next == ST_PURGE)
            w_next_type = i_type_sel;
        else if (w_next == ST_PURGE || w_next == ST_IRRIGATE)
            w_next_type = r_type;
    end

    assign o_state             = r_state;
    assign o_irrigation_type   = r_type;
    assign o_pulse_transiction = r_pulse;
    assign o_purge_on          = r_purge;
    assign o_valve_on          = r_valve;
    assign o_alarm             = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irrigation_sequencer
//  Purpose  : Randomized bench for irrigation_sequencer with a behavioural
//             timer and a reference model written in terms of "cycles since
//             state entry" and "cycle of arming".
//  Revision : 1.0  initial release
// ============================================================================
module tb_irrigation_sequencer;

    localparam int ARM_MAX     = 4;
    localparam int WDOG_CYCLES = 63;
    localparam int WDOG_W      = 6;
    localparam int N_CYCLES    = 6000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, humidity_low, water_low, fault_clr, timer_done;
    logic [1:0] type_sel;
    logic [1:0] state, irrigation_type;
    logic       pulse, purge_on, valve_on, alarm;

    always #5 clk = ~clk;

    irrigation_sequencer #(
        .ARM_MAX     (ARM_MAX),
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start             (start),
        .i_humidity_low      (humidity_low),
        .i_water_low         (water_low),
        .i_type_sel          (type_sel),
        .i_fault_clr         (fault_clr),
        .i_timer_done        (timer_done),
        .o_state             (state),
        .o_irrigation_type   (irrigation_type),
        .o_pulse_transiction (pulse),
        .o_purge_on          (purge_on),
        .o_valve_on          (valve_on),
        .o_alarm             (alarm)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // state: 0 idle, 1 purge, 2 irrigate, 3 fault
    int m_state, m_type, m_pulse, m_ent, m_armed_at;

    task automatic model_reset();
        m_state = 0; m_type = 0; m_pulse = 0; m_ent = 0; m_armed_at = -1;
    endtask

    task automatic model_step();
        int  nxt;
        bit  running, expd, tout, td;
        td      = timer_done;
        running = (m_state == 1) || (m_state == 2);
        expd    = running && (m_armed_at >= 0) && td;
        tout    = running && (((m_armed_at < 0) && (m_ent >= ARM_MAX) && td) ||
                              ((m_armed_at >= 0) && (m_ent - m_armed_at >= WDOG_CYCLES) && !td));
        nxt = m_state;
        case (m_state)
            0: if (start && humidity_low && !water_low && (type_sel == 2'b01 || type_sel == 2'b10)) nxt = 1;
            1: if (water_low || tout) nxt = 3; else if (expd) nxt = 2;
            2: if (water_low || tout) nxt = 3; else if (expd || !humidity_low) nxt = 0;
            default: if (fault_clr && !water_low) nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_type     = (nxt == 1) ? int'(type_sel) : (nxt == 2) ? m_type : 0;
            m_pulse    = 1;
            m_ent      = 0;
            m_armed_at = -1;
            m_state    = nxt;
        end else begin
            m_pulse = 0;
            if (m_armed_at < 0 && m_ent >= 1 && !td) m_armed_at = m_ent;
            m_ent++;
        end
    endtask

    task automatic compare_all();
        check("state", 8'(state), 8'(m_state));
        check("type",  8'(irrigation_type), 8'(m_type));
        check("pulse", 8'(pulse), 8'(m_pulse));
        check("purge", 8'(purge_on), 8'(m_state == 1));
        check("valve", 8'(valve_on), 8'(m_state == 2));
        check("alarm", 8'(alarm), 8'(m_state == 3));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 8'(state), 8'd0);
        check({tag, "_type"},  8'(irrigation_type), 8'd0);
        check({tag, "_pulse"}, 8'(pulse), 8'd0);
        check({tag, "_valves"}, 8'({purge_on, valve_on, alarm}), 8'd0);
    endtask

    // ---------------- behavioural timer ----------------
    // After a load: t_stale cycles of stale done=1, t_run cycles of 0, then 1.
    int t_since = 100000, t_stale = 0, t_run = 0;

    task automatic timer_reload();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 8) begin            // stuck at 1: arm timeout
            t_stale = 100000; t_run = 0;
        end else if (r < 15) begin  // never finishes: run watchdog
            t_stale = 0; t_run = 100;
        end else if (r < 30) begin  // stale done around the arm limit
            t_stale = int'($urandom_range(1, ARM_MAX)); t_run = int'($urandom_range(1, 12));
        end else begin
            t_stale = int'($urandom_range(0, 1)); t_run = int'($urandom_range(1, 20));
        end
        t_since = -1;
    endtask

    task automatic drive_inputs();
        int r;
        t_since++;
        timer_done   = (t_since < t_stale) ? 1'b1 : (t_since < t_stale + t_run) ? 1'b0 : 1'b1;
        start        = ($urandom_range(0, 3) != 0);
        humidity_low = ($urandom_range(0, 24) != 0);
        if (water_low) water_low = ($urandom_range(0, 3) != 0);
        else           water_low = ($urandom_range(0, 59) == 0);
        fault_clr    = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 5));
        type_sel     = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b00 : 2'b11;
    endtask

    int last_rst = 0;
    int n_async  = 0;

    initial begin
        rst_n = 1'b0; start = 1'b0; humidity_low = 1'b0; water_low = 1'b0;
        fault_clr = 1'b0; timer_done = 1'b1; type_sel = 2'b00;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        rst_n = 1'b1;

        for (int i = 0; i < N_CYCLES && n_errors < 40; i++) begin
            cyc = i;
            drive_inputs();
            @(negedge clk);
            compare_all();
            if (pulse) timer_reload();
            model_step();
            @(posedge clk);
            #1;
            // Occasional asynchronous reset in the middle of a purge.
            if (m_state == 1 && i - last_rst > 300 && n_async < 5) begin
                #3;
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                model_reset();
                t_since = 100000;
                @(posedge clk);
                #1;
                check_all_zero("async_hold");
                rst_n    = 1'b1;
                last_rst = i;
                n_async++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
